multiplier_param_reg_pp: RTL and testbench

//  Parametrised, pipelined integer multiplier; next generation of the fixed 64b reg_pp multiplier.

---
 rtl/multiplier_param_reg_pp_if.sv | 21 ++
 rtl/multiplier_param_reg_pp.sv | 131 +++++++++++++
 tb/tb_multiplier_param_reg_pp.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_param_reg_pp_if.sv
// Operand/product bundle for multiplier_param_reg_pp: sample in (with valid and sign mode), product out.
interface multiplier_param_reg_pp_if #(
  parameter int IWIDTH = 64
);
  logic                  iValid;
  logic                  iSigned;
  logic [IWIDTH-1:0]     iData0;
  logic [IWIDTH-1:0]     iData1;
  logic                  oValid;
  logic [2*IWIDTH-1:0]   oData;

  modport master (
    output iValid, iSigned, iData0, iData1,
    input  oValid, oData
  );

  modport slave (
    input  iValid, iSigned, iData0, iData1,
    output oValid, oData
  );
endinterface

// File: rtl/multiplier_param_reg_pp.sv
// Pipelined IWIDTH x IWIDTH multiplier, per-sample signed/unsigned, PPCYCLE register stages.
// Define MULT_PP_ACC_EN to turn the final stage into a multiply-accumulate register.
module multiplier_param_reg_pp #(
  parameter int IWIDTH  = 64,
  parameter int PPCYCLE = 3
) (
  input  logic                      iClk,
  input  logic                      iRstN,
  input  logic                      iEn,
  input  logic                      iClr,
  multiplier_param_reg_pp_if.slave  bus
);

  localparam int PW = 2 * IWIDTH;
  localparam int NS = (PPCYCLE > 1) ? PPCYCLE - 1 : 1;

`ifdef MULT_PP_ACC_EN
  localparam bit AccEn = 1'b1;
`else
  localparam bit AccEn = 1'b0;
`endif

  function automatic logic [PW-1:0] signExt(input logic [IWIDTH-1:0] a, input logic sgn);
    return {{IWIDTH{sgn & a[IWIDTH-1]}}, a};
  endfunction

  // Sum of partial-product rows lo..hi-1 modulo 2^PW. In signed mode the top multiplier
  // bit carries weight -2^(IWIDTH-1), so its row is subtracted instead of added.
  function automatic logic [PW-1:0] rowSum(input logic [PW-1:0] a, input logic [IWIDTH-1:0] b,
                                           input logic sgn, input int lo, input int hi);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < IWIDTH; i++) begin
      if (i >= lo && i < hi && b[i]) begin
        if (sgn && i == IWIDTH - 1) s = s - (a << i);
        else                        s = s + (a << i);
      end
    end
    return s;
  endfunction

  function automatic int rowLo(input int k);
    return ((k - 1) * IWIDTH) / NS;
  endfunction

  function automatic int rowHi(input int k);
    return (k * IWIDTH) / NS;
  endfunction

  if (PPCYCLE == 1) begin : gSingle
    logic [PW-1:0] prod;
    logic [PW-1:0] data_p0;
    logic          vld_p0;

    always_comb prod = rowSum(signExt(bus.iData0, bus.iSigned), bus.iData1, bus.iSigned, 0, IWIDTH);

    // stage 1: full product (or accumulate) in one register
    always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
        data_p0 <= '0;
        vld_p0  <= 1'b0;
      end else if (iClr) begin
        data_p0 <= '0;
        vld_p0  <= 1'b0;
      end else if (iEn) begin
        vld_p0 <= bus.iValid;
        if (!AccEn)           data_p0 <= prod;
        else if (bus.iValid)  data_p0 <= data_p0 + prod;
      end
    end

    assign bus.oData  = data_p0;
    assign bus.oValid = vld_p0;
  end else begin : gPipe
    logic [PW-1:0]     a_p   [PPCYCLE];
    logic [IWIDTH-1:0] b_p   [PPCYCLE];
    logic              sgn_p [PPCYCLE];
    logic              vld_p [PPCYCLE];
    logic [PW-1:0]     acc_p [PPCYCLE];
    logic [PW-1:0]     rows  [PPCYCLE];

    always_comb begin
      rows[0] = '0;
      for (int k = 1; k < PPCYCLE; k++)
        rows[k] = rowSum(a_p[k-1], b_p[k-1], sgn_p[k-1], rowLo(k), rowHi(k));
    end

    always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
        for (int k = 0; k < PPCYCLE; k++) begin
          a_p[k]   <= '0;
          b_p[k]   <= '0;
          sgn_p[k] <= 1'b0;
          vld_p[k] <= 1'b0;
          acc_p[k] <= '0;
        end
      end else if (iClr) begin
        for (int k = 0; k < PPCYCLE; k++) begin
          a_p[k]   <= '0;
          b_p[k]   <= '0;
          sgn_p[k] <= 1'b0;
          vld_p[k] <= 1'b0;
          acc_p[k] <= '0;
        end
      end else if (iEn) begin
        // stage 1: operands, sign mode and valid
        a_p[0]   <= signExt(bus.iData0, bus.iSigned);
        b_p[0]   <= bus.iData1;
        sgn_p[0] <= bus.iSigned;
        vld_p[0] <= bus.iValid;
        acc_p[0] <= '0;
        // stages 2..PPCYCLE: each folds in its share of partial-product rows
        for (int k = 1; k < PPCYCLE; k++) begin
          a_p[k]   <= a_p[k-1];
          b_p[k]   <= b_p[k-1];
          sgn_p[k] <= sgn_p[k-1];
          vld_p[k] <= vld_p[k-1];
          if (AccEn && k == PPCYCLE - 1) begin
            if (vld_p[k-1]) acc_p[k] <= acc_p[k] + acc_p[k-1] + rows[k];
          end else begin
            acc_p[k] <= acc_p[k-1] + rows[k];
          end
        end
      end
    end

    assign bus.oData  = acc_p[PPCYCLE-1];
    assign bus.oValid = vld_p[PPCYCLE-1];
  end

endmodule

// File: tb/tb_multiplier_param_reg_pp.sv
// Bench for multiplier_param_reg_pp: 64b/3-stage DUT against a delay-line product model,
// plus 8b sweep instances at PPCYCLE=1 and PPCYCLE=5.
module tb_multiplier_param_reg_pp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN, en, clr, enS, clrS;

  multiplier_param_reg_pp_if #(.IWIDTH(64)) m ();
  multiplier_param_reg_pp_if #(.IWIDTH(8))  s1 ();
  multiplier_param_reg_pp_if #(.IWIDTH(8))  s5 ();

  multiplier_param_reg_pp #(.IWIDTH(64), .PPCYCLE(3)) dut (
    .iClk(clk), .iRstN(rstN), .iEn(en), .iClr(clr), .bus(m.slave));
  multiplier_param_reg_pp #(.IWIDTH(8), .PPCYCLE(1)) dutS1 (
    .iClk(clk), .iRstN(rstN), .iEn(enS), .iClr(clrS), .bus(s1.slave));
  multiplier_param_reg_pp #(.IWIDTH(8), .PPCYCLE(5)) dutS5 (
    .iClk(clk), .iRstN(rstN), .iEn(enS), .iClr(clrS), .bus(s5.slave));

`ifdef MULT_PP_ACC_EN
  localparam logic [127:0] SwpSig  = 128'hFE02;
  localparam logic [127:0] SwpIdle = 128'hFE02;
`else
  localparam logic [127:0] SwpSig  = 128'h0001;
  localparam logic [127:0] SwpIdle = 128'h0000;
`endif

  int nVec  = 0;
  int nFail = 0;
  bit checkOn = 1'b0;

  function automatic logic [127:0] refMul(input logic s, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb;
    if (s) begin
      sa = {{64{a[63]}}, a};
      sb = {{64{b[63]}}, b};
    end else begin
      sa = {64'b0, a};
      sb = {64'b0, b};
    end
    return sa * sb;
  endfunction

  // Reference: full product computed at capture, then delayed by the pipeline depth
  logic         mv0, mv1, mOutV;
  logic [127:0] md0, md1, mOutD;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mv0 <= 1'b0; mv1 <= 1'b0; mOutV <= 1'b0;
      md0 <= '0;   md1 <= '0;   mOutD <= '0;
    end else if (clr) begin
      mv0 <= 1'b0; mv1 <= 1'b0; mOutV <= 1'b0;
      md0 <= '0;   md1 <= '0;   mOutD <= '0;
    end else if (en) begin
      mv0   <= m.iValid;
      md0   <= refMul(m.iSigned, m.iData0, m.iData1);
      mv1   <= mv0;
      md1   <= md0;
      mOutV <= mv1;
`ifdef MULT_PP_ACC_EN
      if (mv1) mOutD <= mOutD + md1;
`else
      mOutD <= md1;
`endif
    end
  end

  always @(negedge clk) begin
    if (checkOn) begin
      nVec++;
      if (m.oValid !== mOutV || m.oData !== mOutD) begin
        nFail++;
        $display("FAIL pipe t=%0t got v=%b d=%h want v=%b d=%h", $time, m.oValid, m.oData, mOutV, mOutD);
      end
    end
  end

  task automatic checkVal(input string name, input logic actV, input logic [127:0] actD,
                          input logic expV, input logic [127:0] expD);
    nVec++;
    if (actV !== expV || actD !== expD) begin
      nFail++;
      $display("FAIL %s: got v=%b d=%h want v=%b d=%h", name, actV, actD, expV, expD);
    end
  endtask

  task automatic checkLit(input string name, input logic expV, input logic [127:0] expD);
    checkVal(name, m.oValid, m.oData, expV, expD);
    checkVal({name, "/model"}, mOutV, mOutD, expV, expD);
  endtask

  task automatic push(input logic v, input logic s, input logic [63:0] a, input logic [63:0] b);
    m.iValid = v; m.iSigned = s; m.iData0 = a; m.iData1 = b;
    @(negedge clk);
  endtask

  task automatic driveS(input logic v, input logic s, input logic [7:0] a, input logic [7:0] b);
    s1.iValid = v; s1.iSigned = s; s1.iData0 = a; s1.iData1 = b;
    s5.iValid = v; s5.iSigned = s; s5.iData0 = a; s5.iData1 = b;
  endtask

  initial begin
    rstN = 1'b1; en = 1'b1; clr = 1'b0; enS = 1'b0; clrS = 1'b0;
    m.iValid = 1'b1; m.iSigned = 1'b0; m.iData0 = '1; m.iData1 = '1;
    driveS(1'b0, 1'b0, 8'h00, 8'h00);
    #1 rstN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOn = 1'b1;
    checkLit("reset", 1'b0, 128'h0);
    checkVal("resetS1", s1.oValid, {112'b0, s1.oData}, 1'b0, 128'h0);
    checkVal("resetS5", s5.oValid, {112'b0, s5.oData}, 1'b0, 128'h0);
    rstN = 1'b1; enS = 1'b1;

`ifndef MULT_PP_ACC_EN
    push(1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    push(1'b0, 1'b0, 64'h0, 64'h0);
    push(1'b0, 1'b0, 64'h0, 64'h0);
    checkLit("uMax", 1'b1, 128'hFFFFFFFFFFFFFFFE0000000000000001);
    push(1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    push(1'b0, 1'b0, 64'h0, 64'h0);
    push(1'b0, 1'b0, 64'h0, 64'h0);
    checkLit("sNegOne", 1'b1, 128'h1);
    push(1'b1, 1'b1, 64'h8000000000000000, 64'h8000000000000000);
    push(1'b0, 1'b0, 64'h0, 64'h0);
    push(1'b0, 1'b0, 64'h0, 64'h0);
    checkLit("sMinSq", 1'b1, 128'h40000000000000000000000000000000);
    push(1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFD, 64'h5);
    push(1'b0, 1'b0, 64'h0, 64'h0);
    push(1'b0, 1'b0, 64'h0, 64'h0);
    checkLit("sM3x5", 1'b1, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF1);
`endif

    for (int i = 0; i < 100; i++) begin
      push(1'b1, 1'($urandom_range(1, 0)), {$urandom, $urandom}, {$urandom, $urandom});
      if (i >= 2) begin
        nVec++;
        if (m.oValid !== 1'b1) begin
          nFail++;
          $display("FAIL streamValid i=%0d got %b want 1", i, m.oValid);
        end
      end
    end

    // Stall with two samples in flight
    push(1'b1, 1'b0, 64'd7, 64'd9);
    push(1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFE, 64'd3);
    en = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 64'hDEAD, 64'hBEEF);
    en = 1'b1;
    push(1'b0, 1'b0, 64'h0, 64'h0);
`ifndef MULT_PP_ACC_EN
    checkLit("stall1", 1'b1, 128'd63);
`endif
    push(1'b0, 1'b0, 64'h0, 64'h0);
`ifndef MULT_PP_ACC_EN
    checkLit("stall2", 1'b1, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFA);
`endif

    // Flush with three samples in flight, iEn low to show iClr wins
    push(1'b1, 1'b0, 64'd10, 64'd10);
    push(1'b1, 1'b0, 64'd11, 64'd11);
    push(1'b1, 1'b0, 64'd12, 64'd12);
    clr = 1'b1; en = 1'b0;
    push(1'b1, 1'b0, 64'd13, 64'd13);
    clr = 1'b0; en = 1'b1;
    checkLit("flush", 1'b0, 128'h0);
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 1'b0, 64'h0, 64'h0);
      checkLit("noStale", 1'b0, 128'h0);
    end

`ifdef MULT_PP_ACC_EN
    push(1'b1, 1'b1, 64'd2, 64'd3);
    push(1'b1, 1'b1, 64'd4, 64'd5);
    push(1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'd7);
    checkLit("mac6", 1'b1, 128'd6);
    push(1'b0, 1'b0, 64'h0, 64'h0);
    checkLit("mac26", 1'b1, 128'd26);
    push(1'b0, 1'b0, 64'h0, 64'h0);
    checkLit("mac19", 1'b1, 128'd19);
    push(1'b0, 1'b0, 64'h0, 64'h0);
    checkLit("macHold", 1'b0, 128'd19);
    clr = 1'b1;
    push(1'b0, 1'b0, 64'h0, 64'h0);
    clr = 1'b0;
    checkLit("macClr", 1'b0, 128'h0);
`endif

    // Parameter sweep: 8-bit operands at depth 1 and 5
    driveS(1'b1, 1'b0, 8'hFF, 8'hFF);
    @(negedge clk);
    checkVal("s1Uns", s1.oValid, {112'b0, s1.oData}, 1'b1, 128'hFE01);
    driveS(1'b1, 1'b1, 8'hFF, 8'hFF);
    @(negedge clk);
    checkVal("s1Sig", s1.oValid, {112'b0, s1.oData}, 1'b1, SwpSig);
    driveS(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    checkVal("s1Idle", s1.oValid, {112'b0, s1.oData}, 1'b0, SwpIdle);
    checkVal("s5Early", s5.oValid, {112'b0, s5.oData}, 1'b0, 128'h0);
    @(negedge clk);
    @(negedge clk);
    checkVal("s5Uns", s5.oValid, {112'b0, s5.oData}, 1'b1, 128'hFE01);
    @(negedge clk);
    checkVal("s5Sig", s5.oValid, {112'b0, s5.oData}, 1'b1, SwpSig);
    @(negedge clk);
    checkVal("s5Idle", s5.oValid, {112'b0, s5.oData}, 1'b0, SwpIdle);

    checkOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
